// File: rtl/vp_pkg.sv
// Shared definitions for the DVP filler controller: register map, bit positions
// and the frame-control FSM encoding.
package vp_pkg;

    localparam logic [1:0] ADDR_CTRL       = 2'd0;
    localparam logic [1:0] ADDR_STATUS     = 2'd1;
    localparam logic [1:0] ADDR_LAST_WIDTH = 2'd2;
    localparam logic [1:0] ADDR_LAST_LINES = 2'd3;

    localparam int CTRL_FILL_BIT = 0;
    localparam int CTRL_RUN_BIT  = 1;

    localparam int STAT_ACTIVE_BIT = 0;
    localparam int STAT_SHORT_BIT  = 1;
    localparam int STAT_LONG_BIT   = 2;
    localparam int STAT_VCNT_BIT   = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } vp_state_e;

endpackage

// File: rtl/vp_timing_mon.sv
// Watches the incoming DE stream: measures line width and lines per frame and
// emits single-cycle error pulses; the sticky error bits live in the parent.
module vp_timing_mon
    import vp_pkg::*;
#(
    parameter int H_DISP = 1280,
    parameter int V_DISP = 720,
    parameter int CNT_W  = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pre_de_i,
    input  logic             vs_rise_i,
    output logic [CNT_W-1:0] last_width_o,
    output logic [CNT_W-1:0] last_lines_o,
    output logic             short_p_o,
    output logic             long_p_o,
    output logic             vcnt_p_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] H_EXP   = CNT_W'(H_DISP);
    localparam logic [CNT_W-1:0] V_EXP   = CNT_W'(V_DISP);

    logic             de_d_q;
    logic             de_fall;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic [CNT_W-1:0] lw_q, lw_d;
    logic [CNT_W-1:0] ll_q, ll_d;

    always_comb begin
        de_fall   = de_d_q & ~pre_de_i;
        wcnt_d    = wcnt_q;
        lcnt_d    = lcnt_q;
        lw_d      = lw_q;
        ll_d      = ll_q;
        short_p_o = 1'b0;
        long_p_o  = 1'b0;
        vcnt_p_o  = 1'b0;

        if (pre_de_i) begin
            if (wcnt_q != CNT_MAX) wcnt_d = wcnt_q + CNT_W'(1);
        end else if (de_fall) begin
            lw_d      = wcnt_q;
            short_p_o = (wcnt_q < H_EXP);
            long_p_o  = (wcnt_q > H_EXP);
            wcnt_d    = '0;
            if (lcnt_q != CNT_MAX) lcnt_d = lcnt_q + CNT_W'(1);
        end

        // A line ending in the same cycle as the VS edge still belongs to the closing frame.
        if (vs_rise_i) begin
            ll_d     = lcnt_d;
            vcnt_p_o = (lcnt_d != V_EXP) && (lcnt_d != '0);
            lcnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            de_d_q <= 1'b0;
            wcnt_q <= '0;
            lcnt_q <= '0;
            lw_q   <= '0;
            ll_q   <= '0;
        end else begin
            de_d_q <= pre_de_i;
            wcnt_q <= wcnt_d;
            lcnt_q <= lcnt_d;
            lw_q   <= lw_d;
            ll_q   <= ll_d;
        end
    end

    assign last_width_o = lw_q;
    assign last_lines_o = ll_q;

endmodule

// File: rtl/vp_frame_ctrl.sv
// Frame-synchronous filler controller: register file, sticky errors and the
// FSM that only changes the filler enable on a vertical-sync rising edge.
module vp_frame_ctrl
    import vp_pkg::*;
#(
    parameter int H_DISP = 1280,
    parameter int V_DISP = 720,
    parameter int CNT_W  = 12
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pre_vs_i,
    input  logic        pre_de_i,
    input  logic        cfg_we_i,
    input  logic [1:0]  cfg_addr_i,
    input  logic [15:0] cfg_wdata_i,
    output logic [15:0] cfg_rdata_o,
    output logic        fill_en_o,
    output logic        frame_start_o,
    output logic        err_irq_o,
    output vp_state_e   dbg_state_o
);

    // Config port: cfg_we_i is a single-cycle write strobe with no back-pressure;
    // cfg_rdata_o is valid one cycle after cfg_addr_i is presented.

    vp_state_e        state_q, state_d;
    logic             vs_d_q, vs_rise_q;
    logic             fill_sh_q, fill_sh_d;
    logic             frame_start_q, frame_start_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic [2:0]       sticky_q, sticky_d;
    logic [15:0]      rdata_q, rdata_d;
    logic [2:0]       w1c;
    logic [2:0]       err_set;
    logic             active;
    logic             fill_req, run_req;
    logic [CNT_W-1:0] last_width, last_lines;
    logic             short_p, long_p, vcnt_p;
    logic             unused_wdata;

    assign unused_wdata = ^cfg_wdata_i[15:4];

    vp_timing_mon #(
        .H_DISP (H_DISP),
        .V_DISP (V_DISP),
        .CNT_W  (CNT_W)
    ) u_mon (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pre_de_i     (pre_de_i),
        .vs_rise_i    (vs_rise_q),
        .last_width_o (last_width),
        .last_lines_o (last_lines),
        .short_p_o    (short_p),
        .long_p_o     (long_p),
        .vcnt_p_o     (vcnt_p)
    );

    assign fill_req = ctrl_q[CTRL_FILL_BIT];
    assign run_req  = ctrl_q[CTRL_RUN_BIT];
    assign active   = (state_q == ST_ACTIVE) || (state_q == ST_DRAIN);

    always_comb begin
        state_d       = state_q;
        fill_sh_d     = fill_sh_q;
        frame_start_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                fill_sh_d = 1'b0;
                if (run_req) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (!run_req) begin
                    state_d = ST_IDLE;
                end else if (vs_rise_q) begin
                    state_d       = ST_ACTIVE;
                    fill_sh_d     = fill_req;
                    frame_start_d = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (vs_rise_q) begin
                    fill_sh_d     = fill_req;
                    frame_start_d = 1'b1;
                end
                if (!run_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (vs_rise_q) begin
                    state_d       = ST_IDLE;
                    fill_sh_d     = 1'b0;
                    frame_start_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (cfg_we_i && (cfg_addr_i == ADDR_CTRL)) ctrl_d = cfg_wdata_i[1:0];

        w1c = 3'b000;
        if (cfg_we_i && (cfg_addr_i == ADDR_STATUS)) w1c = cfg_wdata_i[STAT_VCNT_BIT:STAT_SHORT_BIT];

        // Set beats clear so an error landing on a W1C write is never lost.
        err_set  = (state_q != ST_IDLE) ? {vcnt_p, long_p, short_p} : 3'b000;
        sticky_d = (sticky_q & ~w1c) | err_set;

        rdata_d = '0;
        unique case (cfg_addr_i)
            ADDR_CTRL:   rdata_d[1:0] = ctrl_q;
            ADDR_STATUS: begin
                rdata_d[STAT_ACTIVE_BIT] = active;
                rdata_d[STAT_SHORT_BIT]  = sticky_q[0];
                rdata_d[STAT_LONG_BIT]   = sticky_q[1];
                rdata_d[STAT_VCNT_BIT]   = sticky_q[2];
            end
            ADDR_LAST_WIDTH: rdata_d[CNT_W-1:0] = last_width;
            ADDR_LAST_LINES: rdata_d[CNT_W-1:0] = last_lines;
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            vs_d_q        <= 1'b0;
            vs_rise_q     <= 1'b0;
            fill_sh_q     <= 1'b0;
            frame_start_q <= 1'b0;
            ctrl_q        <= '0;
            sticky_q      <= '0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            vs_d_q        <= pre_vs_i;
            vs_rise_q     <= pre_vs_i & ~vs_d_q;
            fill_sh_q     <= fill_sh_d;
            frame_start_q <= frame_start_d;
            ctrl_q        <= ctrl_d;
            sticky_q      <= sticky_d;
            rdata_q       <= rdata_d;
        end
    end

    assign fill_en_o     = active & fill_sh_q;
    assign frame_start_o = frame_start_q;
    assign err_irq_o     = |sticky_q;
    assign cfg_rdata_o   = rdata_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_vp_frame_ctrl.sv
// Directed bench for vp_frame_ctrl: drivers push expected values into a queue,
// a negedge monitor pops them and compares against the live DUT outputs.
module tb_vp_frame_ctrl;

  // Frames are shortened to 6 lines so several full frames fit a short run.
  localparam int V_LINES = 6;

  localparam int S_FILL  = 0;
  localparam int S_FS    = 1;
  localparam int S_ERR   = 2;
  localparam int S_STATE = 3;
  localparam int S_RDATA = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SYNC   = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pre_vs = 1'b0;
  logic        pre_de = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [15:0] cfg_wdata = 16'd0;
  logic [15:0] cfg_rdata;
  logic        fill_en, frame_start, err_irq;
  logic [1:0]  dbg_state;

  logic [15:0] exp_q[$];
  int          sel_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  vp_frame_ctrl #(.H_DISP(1280), .V_DISP(V_LINES), .CNT_W(12)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pre_vs_i      (pre_vs),
    .pre_de_i      (pre_de),
    .cfg_we_i      (cfg_we),
    .cfg_addr_i    (cfg_addr),
    .cfg_wdata_i   (cfg_wdata),
    .cfg_rdata_o   (cfg_rdata),
    .fill_en_o     (fill_en),
    .frame_start_o (frame_start),
    .err_irq_o     (err_irq),
    .dbg_state_o   (dbg_state)
  );

  function automatic string sel_name(input int s);
    case (s)
      S_FILL:  return "fill_en";
      S_FS:    return "frame_start";
      S_ERR:   return "err_irq";
      S_STATE: return "state";
      default: return "cfg_rdata";
    endcase
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    logic [15:0] e, a;
    int s;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      case (s)
        S_FILL:  a = {15'd0, fill_en};
        S_FS:    a = {15'd0, frame_start};
        S_ERR:   a = {15'd0, err_irq};
        S_STATE: a = {14'd0, dbg_state};
        default: a = cfg_rdata;
      endcase
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", sel_name(s), a, e, $time);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int s, input logic [15:0] e);
    exp_q.push_back(e);
    sel_q.push_back(s);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] e);
    cfg_addr = a;
    tick();
    chk(S_RDATA, e);
  endtask

  task automatic line(input int n);
    pre_de = 1'b1;
    repeat (n) tick();
    pre_de = 1'b0;
    repeat (4) tick();
  endtask

  task automatic vs_edge(input logic fb, input logic fa, input logic fs, input logic [1:0] st);
    pre_vs = 1'b1;
    pre_de = 1'b0;
    tick();
    chk(S_FILL, {15'd0, fb});
    chk(S_FS, 16'd0);
    tick();
    chk(S_FILL, {15'd0, fa});
    chk(S_FS, {15'd0, fs});
    chk(S_STATE, {14'd0, st});
    pre_vs = 1'b0;
    tick();
    chk(S_FS, 16'd0);
    tick();
    tick();
  endtask

  initial begin
    // reset
    rst = 1'b1;
    tick();
    tick();
    chk(S_FILL, 0);
    chk(S_FS, 0);
    chk(S_ERR, 0);
    chk(S_STATE, IDLE);
    rst = 1'b0;
    for (int a = 0; a < 4; a++) rd(2'(a), 16'h0000);

    // startup: enable lands two cycles after the first VS rise
    wr(2'd0, 16'h0003);
    tick();
    chk(S_STATE, SYNC);
    vs_edge(1'b0, 1'b1, 1'b1, ACTIVE);
    for (int i = 0; i < V_LINES; i++) line(1280);
    vs_edge(1'b1, 1'b1, 1'b1, ACTIVE);
    rd(2'd2, 16'd1280);
    rd(2'd3, V_LINES);
    rd(2'd1, 16'h0001);
    chk(S_ERR, 0);

    // short line, W1C, and W1C colliding with a new short line
    line(1280);
    line(1000);
    rd(2'd2, 16'd1000);
    rd(2'd1, 16'h0003);
    chk(S_ERR, 1);
    wr(2'd1, 16'h0002);
    rd(2'd1, 16'h0001);
    chk(S_ERR, 0);
    pre_de = 1'b1;
    repeat (1000) tick();
    pre_de = 1'b0;
    cfg_we = 1'b1;
    cfg_addr = 2'd1;
    cfg_wdata = 16'h0002;
    tick();
    cfg_we = 1'b0;
    chk(S_ERR, 1);
    repeat (3) tick();
    rd(2'd1, 16'h0003);
    wr(2'd1, 16'h0002);
    rd(2'd1, 16'h0001);

    // fill_req dropped mid-frame takes effect only at the next VS
    wr(2'd0, 16'h0002);
    tick();
    chk(S_FILL, 1);
    chk(S_STATE, ACTIVE);
    for (int i = 0; i < 3; i++) line(1280);
    // CTRL write coincident with vs_rise: the old fill_req (0) is latched
    pre_vs = 1'b1;
    tick();
    chk(S_FILL, 1);
    cfg_we = 1'b1;
    cfg_addr = 2'd0;
    cfg_wdata = 16'h0003;
    tick();
    cfg_we = 1'b0;
    chk(S_FILL, 0);
    chk(S_FS, 1);
    chk(S_STATE, ACTIVE);
    pre_vs = 1'b0;
    tick();
    tick();
    rd(2'd3, V_LINES);
    rd(2'd1, 16'h0001);
    rd(2'd0, 16'h0003);
    for (int i = 0; i < V_LINES; i++) line(1280);
    vs_edge(1'b0, 1'b1, 1'b1, ACTIVE);

    // stop request: drain until the next VS
    line(1280);
    line(1280);
    wr(2'd0, 16'h0001);
    tick();
    chk(S_STATE, DRAIN);
    chk(S_FILL, 1);
    rd(2'd0, 16'h0001);
    rd(2'd1, 16'h0001);
    for (int i = 0; i < 4; i++) line(1280);
    vs_edge(1'b1, 1'b0, 1'b1, IDLE);
    rd(2'd1, 16'h0000);
    rd(2'd3, V_LINES);

    // saturation
    wr(2'd0, 16'h0003);
    tick();
    chk(S_STATE, SYNC);
    vs_edge(1'b0, 1'b1, 1'b1, ACTIVE);
    line(5000);
    rd(2'd2, 16'h0FFF);
    rd(2'd1, 16'h0005);
    chk(S_ERR, 1);

    // reset mid-line, then a full re-sync
    pre_de = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    pre_de = 1'b0;
    tick();
    chk(S_FILL, 0);
    chk(S_STATE, IDLE);
    chk(S_ERR, 0);
    rst = 1'b0;
    rd(2'd2, 16'h0000);
    vs_edge(1'b0, 1'b0, 1'b0, IDLE);
    wr(2'd0, 16'h0003);
    tick();
    chk(S_STATE, SYNC);
    repeat (5) tick();
    chk(S_STATE, SYNC);
    chk(S_FILL, 0);
    wr(2'd0, 16'h0001);
    tick();
    chk(S_STATE, IDLE);
    wr(2'd0, 16'h0003);
    tick();
    chk(S_STATE, SYNC);
    vs_edge(1'b0, 1'b1, 1'b1, ACTIVE);
    rd(2'd1, 16'h0001);

    // final report
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d unchecked expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
